// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the memory interface stage
//
// Purpose: state and operation enums plus default sizing constants used by
//          mem_interface_ctrl and its bench.
// Ports:   none (package).
package mem_pkg;

  localparam int DEFAULT_ADDR_BITS   = 9;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/sram_sp_32.sv
// rtl/sram_sp_32.sv - single-port 32-bit synchronous RAM, registered read
//
// Purpose: 2^ADDR_BITS x 32 storage array. A write takes priority; otherwise
//          the word at addr appears on rdata one clock later. No reset, so
//          contents survive a controller reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
module sram_sp_32 #(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_interface_ctrl.sv
// rtl/mem_interface_ctrl.sv - MAR/MDR-side memory controller with wait states
//
// Purpose: accepts a read or write request in IDLE, waits WAIT_CYCLES, then
//          accesses the internal RAM. Reads drive the MDR load strobes during
//          the one-cycle DONE pulse.
// Ports:
//   clk             in   clock
//   in_reset        in   asynchronous active-high reset
//   in_read_req     in   read request (sampled in IDLE, wins over write)
//   in_write_req    in   write request (sampled in IDLE)
//   in_mar          in   address from MAR
//   in_mdr          in   write data from MDR
//   out_mem_data    out  last read result
//   out_mdr_select  out  memory selected as MDR source (read DONE only)
//   out_mdr_write   out  MDR write strobe (read DONE only)
//   out_busy        out  transaction in progress
//   out_done        out  one-cycle completion pulse
//   out_addr_fault  out  completing transaction had out-of-range address
module mem_interface_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_BITS   = DEFAULT_ADDR_BITS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        in_reset,
  input  logic        in_read_req,
  input  logic        in_write_req,
  input  logic [31:0] in_mar,
  input  logic [31:0] in_mdr,
  output logic [31:0] out_mem_data,
  output logic        out_mdr_select,
  output logic        out_mdr_write,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_addr_fault
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t               state, state_n;
  logic [CW-1:0]        cnt;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          data_q;
  op_t                  op_q;
  logic                 fault_q;
  logic [31:0]          rd_data;

  logic                 accept;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [31:0]          ram_rdata;

  assign accept = in_read_req | in_write_req;

  // In IDLE the RAM is addressed straight from MAR so the registered read
  // has already completed by the time ACCESS is reached, even with no waits.
  assign ram_addr = (state == IDLE) ? in_mar[ADDR_BITS-1:0] : addr_q;
  assign ram_we   = (state == ACCESS) && (op_q == OP_WRITE) && !fault_q;

  sram_sp_32 #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(data_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = ACCESS;
        end
      end
      ACCESS:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= OP_READ;
      fault_q <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= CW'(WAIT_CYCLES - 1);
            addr_q  <= in_mar[ADDR_BITS-1:0];
            data_q  <= in_mdr;
            op_q    <= in_read_req ? OP_READ : OP_WRITE;
            fault_q <= |in_mar[31:ADDR_BITS];
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        ACCESS: begin
          if (op_q == OP_READ) begin
            rd_data <= fault_q ? 32'd0 : ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_mem_data   = rd_data;
    out_busy       = (state != IDLE);
    out_done       = 1'b0;
    out_mdr_select = 1'b0;
    out_mdr_write  = 1'b0;
    out_addr_fault = 1'b0;
    if (state == DONE) begin
      out_done       = 1'b1;
      out_addr_fault = fault_q;
      out_mdr_select = (op_q == OP_READ);
      out_mdr_write  = (op_q == OP_READ);
    end
  end

endmodule

// File: tb/tb_mem_interface_ctrl.sv
// tb/tb_mem_interface_ctrl.sv - directed self-checking bench for mem_interface_ctrl
module tb_mem_interface_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, rd0 = 1'b0;
  logic [31:0] mar = '0, mdr = '0;

  logic [31:0] mem_data, mem_data0;
  logic        sel, mw, busy, done, fault;
  logic        sel0, mw0, busy0, done0, fault0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_interface_ctrl #(.ADDR_BITS(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .in_reset(rst), .in_read_req(rd), .in_write_req(wr),
    .in_mar(mar), .in_mdr(mdr), .out_mem_data(mem_data),
    .out_mdr_select(sel), .out_mdr_write(mw), .out_busy(busy),
    .out_done(done), .out_addr_fault(fault)
  );

  mem_interface_ctrl #(.ADDR_BITS(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .in_reset(rst), .in_read_req(rd0), .in_write_req(1'b0),
    .in_mar(mar), .in_mdr(mdr), .out_mem_data(mem_data0),
    .out_mdr_select(sel0), .out_mdr_write(mw0), .out_busy(busy0),
    .out_done(done0), .out_addr_fault(fault0)
  );

  task automatic run_txn(input logic rd_i, input logic wr_i,
                         input logic [31:0] mar_i, input logic [31:0] mdr_i,
                         output int lat, output int busy_n, output int stray,
                         output logic [31:0] data_o, output logic f_o,
                         output logic sel_o, output logic mw_o);
    @(negedge clk);
    rd = rd_i; wr = wr_i; mar = mar_i; mdr = mdr_i;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    lat = 1; busy_n = 0; stray = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      if (sel !== 1'b0 || mw !== 1'b0 || fault !== 1'b0) stray++;
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1) busy_n++;
    data_o = mem_data; f_o = fault; sel_o = sel; mw_o = mw;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sel, mw, fault} !== 5'b0 || mem_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%h exp=00000/00000000", {busy, done, sel, mw, fault}, mem_data);
    end
    checks++;
    if ({busy0, done0, sel0, mw0, fault0} !== 5'b0 || mem_data0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs_wc0 got=%b/%h exp=00000/00000000", {busy0, done0, sel0, mw0, fault0}, mem_data0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read;
    int lat, bn, st;
    logic [31:0] d;
    logic f, s, w;
    dut.u_ram.mem[5] = 32'hDEADBEEF;
    run_txn(1'b1, 1'b0, 32'd5, 32'd0, lat, bn, st, d, f, s, w);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL read_latency got=%0d exp=4", lat); end
    checks++;
    if (bn !== 4) begin failures++; $display("FAIL read_busy_cycles got=%0d exp=4", bn); end
    checks++;
    if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", d); end
    checks++;
    if ({s, w, f} !== 3'b110 || st !== 0) begin
      failures++; $display("FAIL read_strobes got=%b stray=%0d exp=110 stray=0", {s, w, f}, st);
    end
    checks++;
    if ({done, sel, mw, busy} !== 4'b0 || mem_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL read_after_done got=%b/%h exp=0000/deadbeef", {done, sel, mw, busy}, mem_data);
    end
  endtask

  task automatic test_write_read;
    int lat, bn, st;
    logic [31:0] d;
    logic f, s, w;
    run_txn(1'b0, 1'b1, 32'h10, 32'h12345678, lat, bn, st, d, f, s, w);
    checks++;
    if (lat !== 4 || {s, w, f} !== 3'b000) begin
      failures++; $display("FAIL write_done got=lat%0d/%b exp=lat4/000", lat, {s, w, f});
    end
    checks++;
    if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL write_keeps_mem_data got=%h exp=deadbeef", d); end
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, lat, bn, st, d, f, s, w);
    checks++;
    if (d !== 32'h12345678 || s !== 1'b1) begin
      failures++; $display("FAIL write_readback got=%h sel=%b exp=12345678 sel=1", d, s);
    end
  endtask

  task automatic test_both_and_busy;
    int lat;
    int extra;
    dut.u_ram.mem[3] = 32'h33333333;
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; mar = 32'd3; mdr = 32'hAAAA5555;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || sel !== 1'b1 || mw !== 1'b1) begin
      failures++; $display("FAIL both_read_wins got=lat%0d sel%b mw%b exp=lat4 sel1 mw1", lat, sel, mw);
    end
    checks++;
    if (mem_data !== 32'h33333333) begin failures++; $display("FAIL both_data got=%h exp=33333333", mem_data); end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL busy_requests_queued got=%0d exp=0", extra); end
    checks++;
    if (dut.u_ram.mem[3] !== 32'h33333333) begin
      failures++; $display("FAIL both_write_dropped got=%h exp=33333333", dut.u_ram.mem[3]);
    end
  endtask

  task automatic test_fault;
    int lat, bn, st;
    logic [31:0] d;
    logic f, s, w;
    dut.u_ram.mem[0] = 32'h00C0FFEE;
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, lat, bn, st, d, f, s, w);
    checks++;
    if (f !== 1'b1 || d !== 32'd0 || lat !== 4) begin
      failures++; $display("FAIL fault_read got=f%b %h lat%0d exp=f1 00000000 lat4", f, d, lat);
    end
    checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL fault_after_done got=%b exp=0", fault); end
    run_txn(1'b0, 1'b1, 32'h200, 32'h11111111, lat, bn, st, d, f, s, w);
    checks++;
    if (f !== 1'b1 || dut.u_ram.mem[0] !== 32'h00C0FFEE) begin
      failures++; $display("FAIL fault_write got=f%b mem0=%h exp=f1 mem0=00c0ffee", f, dut.u_ram.mem[0]);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bn, st;
    int extra;
    logic [31:0] d;
    logic f, s, w;
    run_txn(1'b1, 1'b0, 32'd5, 32'h0, lat, bn, st, d, f, s, w);
    dut.u_ram.mem[7] = 32'h77777777;
    @(negedge clk);
    wr = 1'b1; mar = 32'd7; mdr = 32'hFFFF0000;
    @(negedge clk);
    wr = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sel, mw, fault} !== 5'b0 || mem_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b/%h exp=00000/00000000", {busy, done, sel, mw, fault}, mem_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", extra); end
    checks++;
    if (dut.u_ram.mem[7] !== 32'h77777777) begin
      failures++; $display("FAIL reset_mid_array got=%h exp=77777777", dut.u_ram.mem[7]);
    end
  endtask

  task automatic test_back_to_back;
    int first, prev, n_done, gap_bad;
    logic [31:0] d;
    logic s;
    dut0.u_ram.mem[9] = 32'h0BADF00D;
    first = -1; prev = -1; n_done = 0; gap_bad = 0; d = '0; s = 1'b0;
    @(negedge clk);
    mar = 32'd9; rd0 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        if (first < 0) begin
          first = i; d = mem_data0; s = sel0;
        end else if (i - prev != 3) begin
          gap_bad++;
        end
        prev = i;
        n_done++;
      end
    end
    rd0 = 1'b0;
    checks++;
    if (first !== 2) begin failures++; $display("FAIL wc0_latency got=%0d exp=2", first); end
    checks++;
    if (n_done !== 4 || gap_bad !== 0) begin
      failures++; $display("FAIL wc0_period got=n%0d bad%0d exp=n4 bad0", n_done, gap_bad);
    end
    checks++;
    if (d !== 32'h0BADF00D || s !== 1'b1) begin
      failures++; $display("FAIL wc0_data got=%h sel=%b exp=0badf00d sel=1", d, s);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_both_and_busy();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
